// File: rtl/display_update_scheduler_if.sv
// Request/transaction bundle between the display update scheduler and its
// neighbours: change pulses in, strobe/type out, busy/ack back, status out.
interface display_update_scheduler_if;
  logic       i_time_changed;
  logic       i_config_req;
  logic       i_refresh_tick;
  logic       i_busy;
  logic       i_ack;
  logic       o_stb;
  logic       o_write_config;
  logic       o_busy;
  logic       o_timeout_err;
  logic [7:0] o_xfer_count;

  // Environment side: raises requests and plays the display output block.
  modport master (
    output i_time_changed, i_config_req, i_refresh_tick, i_busy, i_ack,
    input  o_stb, o_write_config, o_busy, o_timeout_err, o_xfer_count
  );

  // Scheduler side.
  modport slave (
    input  i_time_changed, i_config_req, i_refresh_tick, i_busy, i_ack,
    output o_stb, o_write_config, o_busy, o_timeout_err, o_xfer_count
  );
endinterface

// File: rtl/display_update_scheduler.sv
// Arbitrates config and time rewrites to the display output block: one
// transaction in flight, config first, with ack timeout and periodic refresh.
module display_update_scheduler #(
  parameter logic [7:0]  REFRESH_DIV    = 8'd16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  display_update_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_pend_cfg;
  logic        r_pend_time;
  logic        r_write_config;
  logic [7:0]  r_refresh_cnt;
  logic [15:0] r_timeout_cnt;
  logic [7:0]  r_xfer_count;
  logic        r_timeout_err;

  logic        w_stb;
  logic        w_busy;
  logic        w_accept;
  logic        w_ack_done;
  logic        w_timeout;
  logic        w_refresh_wrap;
  logic        w_cfg_pulse;
  logic        w_pend_cfg_next;
  logic        w_pend_time_next;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a branch forgets to assign.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:     if (r_pend_cfg || r_pend_time) w_next_state = ST_ISSUE;
      ST_ISSUE:    if (!bus.i_busy)               w_next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: if (w_ack_done || w_timeout)   w_next_state = ST_IDLE;
      default:                                    w_next_state = ST_IDLE;
    endcase
  end

  // Output and event decode; ack wins over a timeout on the same cycle.
  always_comb begin
    w_stb      = (r_state == ST_ISSUE);
    w_busy     = (r_state != ST_IDLE);
    w_accept   = w_stb && !bus.i_busy;
    w_ack_done = (r_state == ST_WAIT_ACK) && bus.i_ack;
    w_timeout  = (r_state == ST_WAIT_ACK) && !bus.i_ack &&
                 (r_timeout_cnt == TIMEOUT_CYCLES - 16'd1);
  end

  // A refresh wrap is treated exactly like an external config request.
  assign w_refresh_wrap = bus.i_refresh_tick &&
                          (r_refresh_cnt == REFRESH_DIV - 8'd1);
  assign w_cfg_pulse    = bus.i_config_req || w_refresh_wrap;

  // Pending bits: a fresh pulse on the acceptance edge survives the clear;
  // a config completion schedules a digit rewrite; a timeout re-arms the type.
  assign w_pend_cfg_next  = w_cfg_pulse
                         || (r_pend_cfg && !(w_accept && r_write_config))
                         || (w_timeout && r_write_config);
  assign w_pend_time_next = bus.i_time_changed
                         || (r_pend_time && !(w_accept && !r_write_config))
                         || (w_ack_done && r_write_config)
                         || (w_timeout && !r_write_config);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_cfg     <= 1'b1;
      r_pend_time    <= 1'b0;
      r_write_config <= 1'b0;
      r_refresh_cnt  <= 8'd0;
      r_timeout_cnt  <= 16'd0;
      r_xfer_count   <= 8'd0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_pend_cfg  <= w_pend_cfg_next;
      r_pend_time <= w_pend_time_next;

      if (bus.i_refresh_tick) begin
        r_refresh_cnt <= w_refresh_wrap ? 8'd0 : r_refresh_cnt + 8'd1;
      end

      // Type is latched on ISSUE entry and held until back in IDLE.
      if (r_state == ST_IDLE && w_next_state == ST_ISSUE) begin
        r_write_config <= r_pend_cfg;
      end

      if (w_accept) begin
        r_timeout_cnt <= 16'd0;
      end else if (r_state == ST_WAIT_ACK) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end

      if (w_ack_done) begin
        r_xfer_count <= r_xfer_count + 8'd1;
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.o_stb          = w_stb;
  assign bus.o_busy         = w_busy;
  assign bus.o_write_config = r_write_config;
  assign bus.o_timeout_err  = r_timeout_err;
  assign bus.o_xfer_count   = r_xfer_count;

endmodule

// File: doc/display_update_scheduler.md
DISPLAY_UPDATE_SCHEDULER -- requirements
Module: display_update_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 8'd16, meaning the number of i_refresh_tick pulses between forced config rewrites (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096, meaning the number of WAIT_ACK cycles before abandoning a transaction (legal range 2..65535).
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_time_changed, input, 1 bit: single-cycle pulse meaning the time register has changed.
REQ-006 SHALL have port i_config_req, input, 1 bit: single-cycle pulse meaning the display settings have changed.
REQ-007 SHALL have port i_refresh_tick, input, 1 bit: periodic single-cycle pulse (e.g. 1 Hz).
REQ-008 SHALL have port o_stb, output, 1 bit: transaction strobe to the display output block.
REQ-009 SHALL have port o_write_config, output, 1 bit: transaction type, 1 = config write, 0 = time write.
REQ-010 SHALL have port i_busy, input, 1 bit: busy from the display output block.
REQ-011 SHALL have port i_ack, input, 1 bit: single-cycle completion pulse from the display output block.
REQ-012 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port o_timeout_err, output, 1 bit: sticky flag set on an ack timeout.
REQ-014 SHALL have port o_xfer_count, output, 8 bits: count of completed transactions, wrapping.

Function
REQ-015 SHALL implement three states: IDLE, ISSUE and WAIT_ACK.
REQ-016 SHALL hold two sticky pending bits, pend_cfg and pend_time, set on the edge that samples i_config_req or i_time_changed respectively.
REQ-017 SHALL count i_refresh_tick pulses in an 8-bit counter; a tick at count REFRESH_DIV-1 wraps the counter to 0 and sets pend_cfg.
REQ-018 SHALL, in IDLE with any pending bit set, move to ISSUE and register o_write_config = pend_cfg, so config has priority over time.
REQ-019 SHALL drive o_stb = (state == ISSUE) and keep o_write_config stable from ISSUE entry until the return to IDLE.
REQ-020 SHALL move from ISSUE to WAIT_ACK on the edge where o_stb=1 and i_busy=0 (acceptance), and remain in ISSUE while i_busy=1.
REQ-021 SHALL, on acceptance, clear the issued type's pending bit, unless a new pulse of that type is sampled on the same edge, in which case the bit stays set.
REQ-022 SHALL, in WAIT_ACK, return to IDLE on i_ack=1 and increment o_xfer_count mod 256.
REQ-023 SHALL, when a completed transaction was a config write, set pend_time so the digits are rewritten after any config change.
REQ-024 SHALL run a 16-bit cycle counter in WAIT_ACK, cleared on entry, and at count TIMEOUT_CYCLES-1 without i_ack: set o_timeout_err, re-set the issued type's pending bit, and go to IDLE without counting the transaction.
REQ-025 SHALL give priority to i_ack when it arrives on the same cycle as the timeout (normal completion, no error).
REQ-026 SHALL ignore i_ack outside WAIT_ACK.
REQ-027 SHALL NOT queue repeated pulses: multiple pulses of one type while that type is pending collapse into one transaction.
REQ-028 SHALL have a latency of 2 edges: with a pulse sampled at edge k and the block IDLE, ISSUE is entered at edge k+1 and o_stb is high in the cycle after edge k+1.
REQ-029 SHALL clear o_timeout_err only by reset.

Reset
REQ-030 SHALL, with i_reset=1 at an edge, set state=IDLE, pend_cfg=1, pend_time=0, refresh counter=0, timeout counter=0, o_xfer_count=0, o_timeout_err=0, o_write_config=0, o_stb=0 and o_busy=0.
REQ-031 SHALL abandon any in-flight transaction on reset, issuing no further o_stb for it, with pending state as in REQ-030.
REQ-032 SHALL issue a config write as the first transaction after reset, followed by a time write.

Verification
REQ-033 SHALL cover reset release with i_busy=0 and ack after 3 cycles: a config stb (o_write_config=1), then a time stb (0), then o_xfer_count=2.
REQ-034 SHALL cover i_config_req and i_time_changed pulsed on the same cycle in IDLE: config issued first, time second, exactly 2 transactions.
REQ-035 SHALL cover i_busy=1 for 10 cycles during ISSUE: o_stb held 11 cycles, a single acceptance, pend bit cleared only on the acceptance edge.
REQ-036 SHALL cover 16 i_refresh_tick pulses with REFRESH_DIV=16: exactly one config write triggered, on the 16th tick, and the counter back at 0.
REQ-037 SHALL cover TIMEOUT_CYCLES=8 with i_ack never asserted: o_timeout_err=1 after 8 WAIT_ACK cycles, the same type reissued, and o_xfer_count unchanged.
REQ-038 SHALL cover i_reset asserted in WAIT_ACK: next cycle o_busy=0 and o_stb=0, then a fresh config write issued.
